// File: rtl/scoreboard_hazard_unit.sv
// Per-stage destination scoreboard: detects RAW hazards at decode and picks forward sources, zero latency.
// stall holds decode and bubbles stage 1; hold freezes the scoreboard, flush squashes decode and stage 1.
module scoreboard_hazard_unit #(
  parameter  int RW         = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_READY = 2,
  parameter  int FWD_EN     = 1,
  localparam int FW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [NUM_SRC*RW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic [RW-1:0]         id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall,
  output logic [NUM_SRC*FW-1:0] fwd_sel,
  output logic [15:0]           stall_count
);

  logic          entVld  [1:DEPTH];
  logic [RW-1:0] entRd   [1:DEPTH];
  logic          entLoad [1:DEPTH];

  logic [FW-1:0]      prodStage [NUM_SRC];
  logic               prodLoad  [NUM_SRC];
  logic [NUM_SRC-1:0] hazard;
  logic               issue;

  always_comb begin
    hazard  = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      prodStage[i] = '0;
      prodLoad[i]  = 1'b0;
      // Scan oldest to youngest so the youngest match overwrites any older one.
      for (int k = DEPTH; k >= 1; k--) begin
        if (id_valid && id_src_used[i] && (id_src[i*RW +: RW] != '0) &&
            entVld[k] && (entRd[k] == id_src[i*RW +: RW])) begin
          prodStage[i] = FW'(k);
          prodLoad[i]  = entLoad[k];
        end
      end
      if (prodStage[i] != '0) begin
        if (FWD_EN != 0) hazard[i] = prodLoad[i] && (int'(prodStage[i]) < LOAD_READY);
        else             hazard[i] = int'(prodStage[i]) < DEPTH;
      end
      if ((FWD_EN != 0) && !hazard[i]) fwd_sel[i*FW +: FW] = prodStage[i];
    end
  end

  assign stall = (|hazard) && !flush;
  assign issue = id_valid && id_reg_write && (id_rd != '0) && !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        entVld[k]  <= 1'b0;
        entRd[k]   <= '0;
        entLoad[k] <= 1'b0;
      end
      stall_count <= '0;
    end else begin
      if (flush || !hold) begin
        for (int k = DEPTH; k >= 2; k--) begin
          entVld[k]  <= entVld[k-1];
          entRd[k]   <= entRd[k-1];
          entLoad[k] <= entLoad[k-1];
        end
        entVld[1]  <= issue && !flush;
        entRd[1]   <= id_rd;
        entLoad[1] <= id_is_load;
        // The instruction that was in stage 1 is on the wrong path.
        if (flush) entVld[2] <= 1'b0;
      end
      if (stall && !hold && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Drives a forwarding instance and a stall-only instance with the same stimulus and
// compares both against a queue-based model of in-flight destination registers.
module tb_scoreboard_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        hold;
  logic        flush;
  logic        stall1, stall0;
  logic [3:0]  fs1, fs0;
  logic [15:0] cnt1, cnt0;

  always #5 clk = ~clk;

  scoreboard_hazard_unit #(.FWD_EN(1)) dutFwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .hold(hold),
    .flush(flush), .stall(stall1), .fwd_sel(fs1), .stall_count(cnt1));

  scoreboard_hazard_unit #(.FWD_EN(0)) dutStl (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .hold(hold),
    .flush(flush), .stall(stall0), .fwd_sel(fs0), .stall_count(cnt0));

  typedef struct packed {bit v; bit [4:0] rd; bit ld;} ent_t;
  typedef ent_t entQ_t[$];

  entQ_t   q1, q0;          // element 0 = stage 1 (youngest)
  int      c1m, c0m;
  bit      st1m, st0m;
  logic [3:0] fs1m, fs0m;
  int      nChecks = 0;
  int      nErrors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    ent_t b;
    b = '0;
    q1 = {}; q0 = {};
    for (int i = 0; i < 3; i++) begin
      q1.push_back(b);
      q0.push_back(b);
    end
    c1m = 0; c0m = 0;
  endtask

  function automatic void evalModel(input entQ_t q, input bit fwdEn, output bit st, output logic [3:0] fs);
    bit [4:0] s;
    bit found, ld, haz;
    int stage;
    st = 1'b0; fs = '0;
    for (int i = 0; i < 2; i++) begin
      s = id_src[i*5 +: 5];
      found = 1'b0; ld = 1'b0; stage = 0;
      if (id_valid && id_src_used[i] && s != 0)
        for (int k = 0; k < 3; k++)
          if (!found && q[k].v && q[k].rd == s) begin
            found = 1'b1; stage = k + 1; ld = q[k].ld;
          end
      if (found) begin
        haz = fwdEn ? (ld && stage < 2) : (stage < 3);
        if (haz) st = 1'b1;
        else if (fwdEn) fs[i*2 +: 2] = 2'(stage);
      end
    end
    if (flush) st = 1'b0;
  endfunction

  function automatic entQ_t adv(input entQ_t q, input bit st);
    entQ_t r = q;
    ent_t n;
    n.v  = id_valid && id_reg_write && id_rd != 0 && !st && !flush;
    n.rd = id_rd;
    n.ld = id_is_load;
    if (flush || !hold) begin
      void'(r.pop_back());
      r.push_front(n);
      if (flush) r[1].v = 1'b0;
    end
    return r;
  endfunction

  task automatic setIn(input bit v, input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] u,
                       input bit [4:0] rd, input bit rw, input bit ld, input bit h, input bit f);
    id_valid = v; id_src = {s1, s0}; id_src_used = u; id_rd = rd;
    id_reg_write = rw; id_is_load = ld; hold = h; flush = f;
  endtask

  task automatic cyc();
    @(negedge clk);
    evalModel(q1, 1'b1, st1m, fs1m);
    evalModel(q0, 1'b0, st0m, fs0m);
    chk("stall_fwd", stall1, st1m);
    chk("sel_fwd",   fs1, fs1m);
    chk("cnt_fwd",   cnt1, c1m);
    chk("stall_stl", stall0, st0m);
    chk("sel_stl",   fs0, fs0m);
    chk("cnt_stl",   cnt0, c0m);
    @(posedge clk);
    q1 = adv(q1, st1m);
    q0 = adv(q0, st0m);
    if (st1m && !hold && c1m < 65535) c1m++;
    if (st0m && !hold && c0m < 65535) c0m++;
    #1;
  endtask

  task automatic idle(input int n);
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  int base;

  initial begin
    rst = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetModel();
    #3;
    chk("rst_stall", stall1, 0);
    chk("rst_sel",   fs1, 0);
    chk("rst_cnt",   cnt1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // ALU result forwarded from stage 1 then stage 2
    setIn(1, 3, 0, 2'b00, 3, 1, 0, 0, 0); cyc();
    setIn(1, 3, 0, 2'b01, 6, 1, 0, 0, 0); #2;
    chk("alu_s1_stall", stall1, 0);
    chk("alu_s1_sel", fs1[1:0], 1);
    cyc();
    setIn(1, 3, 0, 2'b01, 0, 0, 0, 0, 0); #2;
    chk("alu_s2_sel", fs1[1:0], 2);
    cyc();
    idle(3);

    // load-use: one stall cycle then forward from stage 2
    base = c1m;
    setIn(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cyc();
    setIn(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #2;
    chk("lu_stall", stall1, 1);
    cyc(); #2;
    chk("lu_cnt", cnt1, base + 1);
    chk("lu_stall_off", stall1, 0);
    chk("lu_sel", fs1[1:0], 2);
    cyc();
    idle(3);

    // youngest producer wins: ALU r4 in stage 1 shadows load r4 in stage 2
    setIn(1, 0, 0, 2'b00, 4, 1, 1, 0, 0); cyc();
    setIn(1, 0, 0, 2'b00, 4, 1, 0, 0, 0); cyc();
    setIn(1, 0, 4, 2'b10, 0, 0, 0, 0, 0); #2;
    chk("young_stall", stall1, 0);
    chk("young_sel", fs1[3:2], 1);
    cyc();
    idle(3);

    // r0 never tracked; unused source never matches
    setIn(1, 0, 0, 2'b00, 0, 1, 0, 0, 0); cyc();
    setIn(1, 0, 0, 2'b01, 7, 1, 0, 0, 0); #2;
    chk("r0_stall", stall1, 0);
    chk("r0_sel", fs1, 0);
    cyc();
    setIn(1, 7, 7, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("unused_sel", fs1, 0);
    chk("unused_stall", stall0, 0);
    cyc();
    idle(3);

    // flush squashes the load, then hold freezes a load-use stall
    setIn(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cyc();
    setIn(1, 5, 0, 2'b01, 0, 0, 0, 0, 1); #2;
    chk("flush_stall", stall1, 0);
    cyc();
    setIn(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #2;
    chk("flush_gone_stall", stall1, 0);
    chk("flush_gone_sel", fs1, 0);
    cyc();
    idle(3);
    setIn(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cyc();
    base = c1m;
    setIn(1, 5, 0, 2'b01, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("hold_stall", stall1, 1);
      chk("hold_cnt", cnt1, base);
      cyc();
    end
    setIn(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); cyc(); #2;
    chk("hold_rel_cnt", cnt1, base + 1);
    chk("hold_rel_sel", fs1[1:0], 2);
    cyc();
    idle(3);

    // stall-only mode: two stall cycles, then reset mid-stall
    base = c0m;
    setIn(1, 0, 0, 2'b00, 2, 1, 0, 0, 0); cyc();
    setIn(1, 2, 0, 2'b01, 0, 0, 0, 0, 0); #2;
    chk("so_stall1", stall0, 1);
    chk("so_sel", fs0, 0);
    cyc(); #2;
    chk("so_stall2", stall0, 1);
    cyc(); #2;
    chk("so_stall3", stall0, 0);
    chk("so_cnt", cnt0, base + 2);
    cyc();
    idle(3);
    setIn(1, 0, 0, 2'b00, 2, 1, 0, 0, 0); cyc();
    setIn(1, 2, 0, 2'b01, 0, 0, 0, 0, 0); cyc(); #2;
    chk("so_pre_rst", stall0, 1);
    rst = 1'b0; #1;
    chk("so_rst_stall", stall0, 0);
    chk("so_rst_cnt0", cnt0, 0);
    chk("so_rst_cnt1", cnt1, 0);
    resetModel();
    rst = 1'b1;
    cyc();
    idle(2);

    for (int n = 0; n < 500; n++) begin
      setIn(($urandom % 8) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            ($urandom % 8) == 0, ($urandom % 10) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
